logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (AND/OR/XOR/NAND over W-bit operands) among N requesters. Each requester raises a request with its operands and opcode. The arbiter grants one requester at a time, captures its operands, evaluates, and returns a tagged result. It sits above the basic gate designs as the first shared-resource controller in the lab datapath.

## Interface
Parameters:
- N, 4: number of requesters; 2 ≤ N ≤ 8.
- W, 8: operand/result width.
- IDW, $clog2(N): requester index width (localparam).

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request per requester; bit i = requester i.
- op  input  2N  opcode per requester; op[2i+1:2i] for requester i.
- a_bus  input  N·W  operand A per requester; slice [W·i+W-1:W·i].
- b_bus  input  N·W  operand B per requester, same slicing.
- gnt  output  N  one-hot grant; one-cycle pulse.
- busy  output  1  high whenever the FSM is not in IDLE.
- y  output  W  result; holds its value until the next DONE.
- y_valid  output  1  one-cycle pulse when y is new.
- y_id  output  IDW  index of the requester that owns y.

## Operation
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NAND; all operations are bitwise over W bits.
- FSM states: IDLE → LOAD → EXEC → DONE → IDLE.
  - IDLE: if |req, select winner = first set bit of req scanning ptr+1, ptr+2, … modulo N; go to LOAD. Otherwise stay in IDLE.
  - LOAD: gnt[winner]=1; capture op/a/b slices of winner into internal registers; latch winner id.
  - EXEC: evaluate captured operands; register the result into y_next.
  - DONE: y ← result, y_id ← winner, y_valid=1; ptr ← winner.
- Round-robin pointer ptr resets to N-1 so requester 0 has top priority first.
- Requester protocol: hold req and operands stable until gnt is seen. Deassert req in the cycle after gnt unless another operation is wanted. A req still high in the IDLE following DONE is re-eligible, at lowest priority.
- req dropped during LOAD/EXEC/DONE does not cancel the operation; captured operands complete.
- req and operands are ignored outside IDLE (winner selection) and LOAD (capture).
- Reset (asynchronous, any state): state=IDLE, ptr=N-1, gnt=0, busy=0, y=0, y_valid=0, y_id=0, captured registers=0. An in-flight operation is discarded and no y_valid is issued.

## Timing
- req sampled high at edge k in IDLE:
  - gnt high during cycle k+1 (LOAD).
  - y_valid high during cycle k+3 (DONE).
- Fixed latency of 3 cycles from the sampling edge to y_valid. Throughput is 1 operation per 4 cycles under continuous requests.
- gnt, y_valid, busy, y and y_id are all registered outputs; no combinational path from inputs to outputs.
- busy rises in the cycle after the sampling edge and falls in the cycle after DONE.
- Pointer wrap: winner N-1 → next scan starts at 0.

## Structure
- Shared header logic_unit_defs.vh contains:
  - opcode constants OP_AND, OP_OR, OP_XOR, OP_NAND;
  - FSM state encodings S_IDLE, S_LOAD, S_EXEC, S_DONE (2-bit).
- Sub-module logic_unit (combinational: op, a, b → y, W-wide) is instantiated once in EXEC's datapath. The arbiter FSM, pointer and round-robin scan stay in logic_unit_arbiter.

## Test plan
- Single requester: req=0001, op0=00, a0=8'hF0, b0=8'h3C → gnt=0001 at k+1; y=8'h30, y_id=0, y_valid pulse at k+3; busy high for cycles k+1..k+3.
- All ops on requester 2: a=8'hA5, b=8'h0F, op 00/01/10/11 → y = 05 / AF / AA / FA respectively, y_id=2.
- Simultaneous req=1111 held continuously from reset → grant order 0,1,2,3,0 (pointer wraps 3 → 0); y_valid every 4 cycles.
- Fairness: req=0101 held, then requester 0 re-requests immediately after its DONE → requester 2 granted before requester 0 again.
- Mid-operation disruptions:
  - rst_n pulsed low during EXEC → outputs immediately 0, no y_valid, next req=0001 granted normally.
  - Separately, req dropped during EXEC → result still delivered.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter slice.
//   - Opcode constants for the bitwise logic unit.
//   - FSM state encoding (2-bit) for the arbiter sequencer.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational W-bit bitwise logic unit.
// Ports:
//   op  in  2  opcode (AND / OR / XOR / NAND)
//   a   in  W  operand A
//   b   in  W  operand B
//   y   out W  bitwise result
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one logic unit among N requesters.
// Each operation walks IDLE -> LOAD -> EXEC -> DONE -> IDLE.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   req   [N]      request per requester
//   op    [2N]     opcode per requester, op[2i+1:2i]
//   a_bus [N*W]    operand A per requester, a_bus[W*i +: W]
//   b_bus [N*W]    operand B per requester
//   gnt   [N]      one-hot grant pulse (LOAD cycle)
//   busy           FSM not in IDLE
//   y     [W]      result, held until next DONE
//   y_valid        one-cycle pulse in DONE
//   y_id  [IDW]    requester that owns y
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [2*N-1:0]   op,
  input  logic [N*W-1:0]   a_bus,
  input  logic [N*W-1:0]   b_bus,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic [W-1:0]     y,
  output logic             y_valid,
  output logic [IDW-1:0]   y_id
);

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } lu_req_t;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win_q, win_d;
  lu_req_t        cap_q, cap_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   y_q, y_d;
  logic           y_valid_q, y_valid_d;
  logic [IDW-1:0] y_id_q, y_id_d;

  logic [W-1:0]   lu_y;

  // Round-robin scan: first requester at ptr+1, ptr+2, ... (mod N).
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Operand mux for the latched winner, used only when capturing in LOAD.
  lu_req_t win_req;

  always_comb begin
    win_req = '0;
    for (int i = 0; i < N; i++) begin
      if (win_q == IDW'(i)) begin
        win_req.op = op[2*i +: 2];
        win_req.a  = a_bus[W*i +: W];
        win_req.b  = b_bus[W*i +: W];
      end
    end
  end

  logic_unit #(.W(W)) u_lu (
    .op (cap_q.op),
    .a  (cap_q.a),
    .b  (cap_q.b),
    .y  (lu_y)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cap_d     = cap_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    y_id_d    = y_id_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOAD;
          win_d   = pick;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        // Requester holds operands while gnt is visible, so capture here.
        cap_d   = win_req;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Result is registered on the way into DONE so it is visible
        // together with the y_valid pulse.
        y_d       = lu_y;
        y_id_d    = win_q;
        y_valid_d = 1'b1;
        ptr_d     = win_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDW'(N-1);
      win_q     <= '0;
      cap_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cap_q     <= cap_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_id_q    <= y_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_id    = y_id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table, hand-written
// multi-cycle sequences, and randomized transactions against a model.
module tb_logic_unit_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op;
  logic [N*W-1:0]   a_bus, b_bus;
  logic [N-1:0]     gnt;
  logic             busy;
  logic [W-1:0]     y;
  logic             y_valid;
  logic [IDW-1:0]   y_id;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;

  logic_unit_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .gnt     (gnt),
    .busy    (busy),
    .y       (y),
    .y_valid (y_valid),
    .y_id    (y_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference logic unit, straight from the opcode table.
  function automatic logic [W-1:0] lu_ref(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Reference round-robin: first set request after the last winner, cyclically.
  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_bus();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    req   = '0;
    op    = '0;
    a_bus = '0;
    b_bus = '0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_gnt",  32'(gnt),     32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_y",    32'(y),       32'd0);
    chk("rst_yv",   32'(y_valid), 32'd0);
    chk("rst_yid",  32'(y_id),    32'd0);
    rst_n     = 1'b1;
    model_ptr = N - 1;
  endtask

  // One full transaction; caller guarantees the DUT is in IDLE.
  // Request and operands are scrambled/dropped in EXEC once gnt was seen.
  task automatic run_txn(input logic [N-1:0] r, input logic [2*N-1:0] o,
                         input logic [N*W-1:0] av, input logic [N*W-1:0] bv,
                         input int eid, input logic [W-1:0] ey);
    req = r; op = o; a_bus = av; b_bus = bv;
    step();
    chk("gnt_load",  32'(gnt),     32'(1 << eid));
    chk("busy_load", 32'(busy),    32'd1);
    chk("yv_load",   32'(y_valid), 32'd0);
    step();
    chk("gnt_exec",  32'(gnt),     32'd0);
    chk("busy_exec", 32'(busy),    32'd1);
    req = '0; op = (2*N)'($urandom); a_bus = rand_bus(); b_bus = rand_bus();
    step();
    chk("yv_done",   32'(y_valid), 32'd1);
    chk("y_done",    32'(y),       32'(ey));
    chk("yid_done",  32'(y_id),    32'(eid));
    chk("busy_done", 32'(busy),    32'd1);
    step();
    chk("yv_idle",   32'(y_valid), 32'd0);
    chk("busy_idle", 32'(busy),    32'd0);
    chk("y_hold",    32'(y),       32'(ey));
    model_ptr = eid;
  endtask

  // Transaction with request and operands left untouched throughout.
  task automatic run_held(input int eid);
    logic [W-1:0] ey;
    ey = lu_ref(op[2*eid +: 2], a_bus[eid*W +: W], b_bus[eid*W +: W]);
    step();
    chk("h_gnt",  32'(gnt),     32'(1 << eid));
    chk("h_busy", 32'(busy),    32'd1);
    step();
    chk("h_gnt0", 32'(gnt),     32'd0);
    step();
    chk("h_yv",   32'(y_valid), 32'd1);
    chk("h_yid",  32'(y_id),    32'(eid));
    chk("h_y",    32'(y),       32'(ey));
    step();
    chk("h_yv0",  32'(y_valid), 32'd0);
    chk("h_idle", 32'(busy),    32'd0);
    model_ptr = eid;
  endtask

  typedef struct {
    logic [N-1:0] r;
    int           slot;
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ey;
    int           eid;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [N*W-1:0]  av, bv;
    logic [2*N-1:0]  ov;
    logic [N-1:0]    r;
    int              w;

    tbl[0] = '{4'b0001, 0, 2'b00, 8'hF0, 8'h3C, 8'h30, 0};
    tbl[1] = '{4'b0100, 2, 2'b00, 8'hA5, 8'h0F, 8'h05, 2};
    tbl[2] = '{4'b0100, 2, 2'b01, 8'hA5, 8'h0F, 8'hAF, 2};
    tbl[3] = '{4'b0100, 2, 2'b10, 8'hA5, 8'h0F, 8'hAA, 2};
    tbl[4] = '{4'b0100, 2, 2'b11, 8'hA5, 8'h0F, 8'hFA, 2};

    do_reset();

    foreach (tbl[i]) begin
      av = rand_bus(); bv = rand_bus(); ov = (2*N)'($urandom);
      av[tbl[i].slot*W +: W] = tbl[i].a;
      bv[tbl[i].slot*W +: W] = tbl[i].b;
      ov[2*tbl[i].slot +: 2] = tbl[i].o;
      run_txn(tbl[i].r, ov, av, bv, tbl[i].eid, tbl[i].ey);
    end

    // All requesters held from reset: 0,1,2,3 then wrap to 0.
    do_reset();
    req = 4'b1111; op = 8'b11_10_01_00;
    a_bus = 32'h9C_5A_3F_F0; b_bus = 32'h0F_FF_C3_3C;
    for (int j = 0; j < 5; j++) run_held(j % N);

    // Fairness: 0 keeps requesting, 2 must be served before 0 repeats.
    do_reset();
    req = 4'b0101; op = 8'b00_10_00_01;
    a_bus = 32'h00_81_00_12; b_bus = 32'h00_18_00_21;
    run_held(0);
    run_held(2);
    run_held(0);
    req = '0;

    // Reset asserted during EXEC discards the operation.
    av = rand_bus(); bv = rand_bus();
    req = 4'b0001; op = 8'b00_00_00_01; a_bus = av; b_bus = bv;
    step();
    chk("mr_gnt", 32'(gnt), 32'd1);
    step();
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy),    32'd0);
    chk("mr_yv",   32'(y_valid), 32'd0);
    chk("mr_y",    32'(y),       32'd0);
    chk("mr_yid",  32'(y_id),    32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("mr_noyv", 32'(y_valid), 32'd0);
    end
    rst_n = 1'b1;
    model_ptr = N - 1;
    step();
    chk("mr_after_yv", 32'(y_valid), 32'd0);
    av = rand_bus(); bv = rand_bus();
    run_txn(4'b0001, 8'b00_00_00_10, av, bv, 0, lu_ref(2'b10, av[W-1:0], bv[W-1:0]));

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      if (r == '0) begin
        req = '0;
        step();
        chk("rnd_nognt", 32'(gnt),  32'd0);
        chk("rnd_nobsy", 32'(busy), 32'd0);
      end else begin
        av = rand_bus(); bv = rand_bus(); ov = (2*N)'($urandom);
        w = rr_ref(r, model_ptr);
        run_txn(r, ov, av, bv, w, lu_ref(ov[2*w +: 2], av[w*W +: W], bv[w*W +: W]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
